// File: rtl/seq1001_pkg.sv
// Shared types and constants for the overlapping "1001" Moore detector.
package seq1001_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned PAT_W   = 4;

   // Target sequence, oldest bit in the MSB.
   localparam logic [PAT_W-1:0] PATTERN = 4'b1001;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      S1     = 3'd1,
      S10    = 3'd2,
      S100   = 3'd3,
      DETECT = 3'd4
   } state_e;

endpackage : seq1001_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with increment-enable and async active-low clear.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   // Holds at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/seq_detector_1001_moore_1bit_overlapping.sv
// Moore detector for "1001" with one-bit overlap; optional detection counter
// enabled by defining SEQ1001_DETCNT_EN (otherwise det_cnt is tied to 0).
module seq_detector_1001_moore_1bit_overlapping
   import seq1001_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic             dout,
   output logic [CNT_W-1:0] det_cnt
);

   state_e state;
   state_e state_next;
   logic   din_one;

   // Anything other than a clean 1 (including X/Z) is taken as 0.
   assign din_one = (din === 1'b1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // DETECT behaves like S1 so the trailing 1 starts the next match.
   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:        state_next = (din_one == PATTERN[3]) ? S1     : IDLE;
         S1, DETECT:  state_next = (din_one == PATTERN[2]) ? S10    : S1;
         S10:         state_next = (din_one == PATTERN[1]) ? S100   : S1;
         S100:        state_next = (din_one == PATTERN[0]) ? DETECT : IDLE;
         default:     state_next = IDLE;
      endcase
   end

   assign dout = (state == DETECT);

`ifdef SEQ1001_DETCNT_EN
   logic cnt_inc;

   // Count on the edge that enters DETECT, so det_cnt moves with dout.
   assign cnt_inc = (state_next == DETECT) && (state != DETECT);

   sat_counter #(
      .W (CNT_W)
   ) u_det_cnt (
      .clk   (clk),
      .rst_n (rst),
      .inc   (cnt_inc),
      .cnt   (det_cnt)
   );
`else
   assign det_cnt = CNT_W'(0);
`endif

endmodule : seq_detector_1001_moore_1bit_overlapping

// File: tb/tb_seq_detector_1001_moore_1bit_overlapping.sv
// Bench for the "1001" detector: vector table, hand sequences, then random
// stimulus against a sliding-window reference model.
module tb_seq_detector_1001_moore_1bit_overlapping;

   logic       clk;
   logic       rst;
   logic       din;
   logic       dout;
   logic       dout2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int unsigned nvec  = 0;
   int unsigned nfail = 0;

   // Reference model: last four bits since reset and total matches seen.
   logic [3:0]  hist  = '0;
   int unsigned nbits = 0;
   int unsigned mcnt  = 0;

   typedef struct {
      logic        r;
      logic        d;
      logic        o;
      int unsigned c;
   } vec_t;

   vec_t tbl[$];

   seq_detector_1001_moore_1bit_overlapping #(.CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout), .det_cnt(cnt8)
   );

   seq_detector_1001_moore_1bit_overlapping #(.CNT_W(2)) u_dut_w2 (
      .clk(clk), .rst(rst), .din(din), .dout(dout2), .det_cnt(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "timeout");
   end

   function automatic int unsigned exp_cnt(input int unsigned n, input int unsigned max);
`ifdef SEQ1001_DETCNT_EN
      return (n > max) ? max : n;
`else
      return 0 + (n & max & 0);
`endif
   endfunction

   task automatic check(input string nm, input int unsigned act, input int unsigned exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist  = '0;
      nbits = 0;
      mcnt  = 0;
   endtask

   // Drive on the falling edge, check #1 after the rising edge.
   task automatic step(input logic r, input logic d);
      logic exp_o;
      @(negedge clk);
      rst = r;
      din = d;
      if (!r) begin
         model_reset();
      end else begin
         hist = {hist[2:0], d};
         if (nbits < 4) nbits++;
         if (nbits >= 4 && hist == 4'b1001) mcnt++;
      end
      exp_o = r && (nbits >= 4) && (hist == 4'b1001);
      @(posedge clk);
      #1;
      check("dout", 32'(dout), 32'(exp_o));
      check("dout_w2", 32'(dout2), 32'(exp_o));
      check("det_cnt", 32'(cnt8), exp_cnt(mcnt, 255));
      check("det_cnt_w2", 32'(cnt2), exp_cnt(mcnt, 3));
   endtask

   initial begin
      // Match; non-match; two overlapping matches; reset inside a partial match.
      tbl.push_back('{1'b1, 1'b1, 1'b0, 0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 2});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 2});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 2});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 3});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 3});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 3});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1});

      rst = 1'b0;
      din = 1'b0;
      model_reset();
      #1;
      check("reset_dout", 32'(dout), 0);
      check("reset_cnt", 32'(cnt8), 0);
      check("reset_cnt_w2", 32'(cnt2), 0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].d);
         check("tbl_dout", 32'(dout), 32'(tbl[i].o));
`ifdef SEQ1001_DETCNT_EN
         check("tbl_cnt", 32'(cnt8), tbl[i].c);
`else
         check("tbl_cnt", 32'(cnt8), 0);
`endif
      end

      // Reset must clear dout and the counter without a clock edge.
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("pre_async_dout", 32'(dout), 1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_dout", 32'(dout), 0);
      check("async_cnt", 32'(cnt8), 0);
      check("async_cnt_w2", 32'(cnt2), 0);
      step(1'b0, 1'b1);

      // Seven chained overlapping matches: narrow counter must hold at 3.
      step(1'b1, 1'b1);
      for (int m = 0; m < 7; m++) begin
         step(1'b1, 1'b0);
         step(1'b1, 1'b0);
         step(1'b1, 1'b1);
      end
`ifdef SEQ1001_DETCNT_EN
      check("sat_w2", 32'(cnt2), 3);
      check("sat_w8", 32'(cnt8), 7);
`else
      check("sat_w2", 32'(cnt2), 0);
      check("sat_w8", 32'(cnt8), 0);
`endif

      for (int k = 0; k < 3000; k++) begin
         step(logic'($urandom_range(0, 299) != 0), logic'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule : tb_seq_detector_1001_moore_1bit_overlapping
